// File: rtl/motor_speed_pid.sv
// motor_speed_pid: closed-loop PID speed controller for one wall-follower motor.
//
// Once every UPDATE_TICKS clk_en ticks (aligned with the tachometer window) the
// target and measured RPM are sampled. A PID update then steps through a short
// FSM on the fast clock, and the clamped 10-bit duty command is published.
//
// Ports:
//   clk_in          125 MHz system clock
//   reset_in        synchronous, active-high reset
//   clk_en          10 kHz single-cycle enable tick
//   enable_in       loop enable; low holds the controller off with cleared state
//   target_rpm_in   commanded RPM, unsigned 10-bit
//   actual_rpm_in   measured RPM, unsigned 10-bit
//   duty_out        PWM duty command, unsigned 10-bit
//   duty_valid_out  single-cycle strobe when duty_out updates
module motor_speed_pid #(
  parameter int unsigned UPDATE_TICKS = 500,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned KP           = 256,
  parameter int unsigned KI           = 0,
  parameter int unsigned KD           = 0,
  parameter int unsigned INTEG_MAX    = 4096,
  parameter int unsigned DUTY_MAX     = 1023
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       clk_en,
  input  logic       enable_in,
  input  logic [9:0] target_rpm_in,
  input  logic [9:0] actual_rpm_in,
  output logic [9:0] duty_out,
  output logic       duty_valid_out
);

  localparam int unsigned CntW = (UPDATE_TICKS > 1) ? $clog2(UPDATE_TICKS) : 1;
  localparam logic [CntW-1:0]     CntLast   = CntW'(UPDATE_TICKS - 1);
  localparam logic signed [31:0]  KpS       = 32'(KP);
  localparam logic signed [31:0]  KiS       = 32'(KI);
  localparam logic signed [31:0]  KdS       = 32'(KD);
  localparam logic signed [31:0]  IntegMaxS = 32'(INTEG_MAX);
  localparam logic signed [39:0]  DutyMaxS  = 40'(DUTY_MAX);

  typedef enum logic [2:0] {StIdle, StErr, StMul, StAcc, StSum, StSat} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [9:0]           tgt_q, tgt_d, act_q, act_d;
  logic signed [11:0]   err_q, err_d, derr_q, derr_d, prev_err_q, prev_err_d;
  logic signed [31:0]   p_q, p_d, d_q, d_d, integ_q, integ_d;
  logic signed [39:0]   s_q, s_d;
  logic                 sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic [9:0]           sat_duty_q, sat_duty_d;
  logic                 out_pend_q, out_pend_d;
  logic [9:0]           duty_q, duty_d;
  logic                 valid_q, valid_d;

  logic                 update_tick;
  logic signed [11:0]   err_new;
  logic signed [31:0]   integ_sum;
  logic                 acc_hold;

  assign update_tick = clk_en && (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    act_d      = act_q;
    err_d      = err_q;
    derr_d     = derr_q;
    prev_err_d = prev_err_q;
    p_d        = p_q;
    d_d        = d_q;
    integ_d    = integ_q;
    s_d        = s_q;
    sat_hi_d   = sat_hi_q;
    sat_lo_d   = sat_lo_q;
    sat_duty_d = sat_duty_q;
    out_pend_d = 1'b0;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    err_new    = '0;
    integ_sum  = '0;
    acc_hold   = 1'b0;

    // Tick counter free-runs regardless of enable_in.
    if (clk_en) begin
      cnt_d = update_tick ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (update_tick) begin
          tgt_d   = target_rpm_in;
          act_d   = actual_rpm_in;
          state_d = StErr;
        end
      end
      StErr: begin
        err_new = $signed({2'b00, tgt_q}) - $signed({2'b00, act_q});
        err_d   = err_new;
        derr_d  = err_new - prev_err_q;
        state_d = StMul;
      end
      StMul: begin
        p_d     = KpS * 32'(err_q);
        d_d     = KdS * 32'(derr_q);
        state_d = StAcc;
      end
      StAcc: begin
        // Anti-windup: stop integrating further into a saturated output.
        acc_hold  = (sat_hi_q && (err_q > 12'sd0)) || (sat_lo_q && (err_q < 12'sd0));
        integ_sum = integ_q + (acc_hold ? 32'sd0 : 32'(err_q));
        if (integ_sum > IntegMaxS) begin
          integ_d = IntegMaxS;
        end else if (integ_sum < -IntegMaxS) begin
          integ_d = -IntegMaxS;
        end else begin
          integ_d = integ_sum;
        end
        prev_err_d = err_q;
        state_d    = StSum;
      end
      StSum: begin
        s_d     = (40'(p_q) + 40'(KiS * integ_q) + 40'(d_q)) >>> FRAC_BITS;
        state_d = StSat;
      end
      StSat: begin
        sat_hi_d = (s_q >= DutyMaxS);
        sat_lo_d = (s_q <= 40'sd0);
        if (s_q >= DutyMaxS) begin
          sat_duty_d = 10'(DUTY_MAX);
        end else if (s_q <= 40'sd0) begin
          sat_duty_d = 10'd0;
        end else begin
          sat_duty_d = s_q[9:0];
        end
        out_pend_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Output stage: publish the clamped result one cycle after SAT.
    if (out_pend_q) begin
      duty_d  = sat_duty_q;
      valid_d = 1'b1;
    end

    // Loop disabled: abort any update and return to a clean, zero-duty state.
    if (!enable_in) begin
      state_d    = StIdle;
      integ_d    = '0;
      prev_err_d = '0;
      sat_hi_d   = 1'b0;
      sat_lo_d   = 1'b0;
      out_pend_d = 1'b0;
      duty_d     = '0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tgt_q      <= '0;
      act_q      <= '0;
      err_q      <= '0;
      derr_q     <= '0;
      prev_err_q <= '0;
      p_q        <= '0;
      d_q        <= '0;
      integ_q    <= '0;
      s_q        <= '0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      sat_duty_q <= '0;
      out_pend_q <= 1'b0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      act_q      <= act_d;
      err_q      <= err_d;
      derr_q     <= derr_d;
      prev_err_q <= prev_err_d;
      p_q        <= p_d;
      d_q        <= d_d;
      integ_q    <= integ_d;
      s_q        <= s_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
      sat_duty_q <= sat_duty_d;
      out_pend_q <= out_pend_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
    end
  end

  assign duty_out       = duty_q;
  assign duty_valid_out = valid_q;

endmodule

// File: tb/tb_motor_speed_pid.sv
// Directed testbench for motor_speed_pid. Five instances with different gain
// sets share one stimulus; each test checks the instance it targets.
module tb_motor_speed_pid;

  localparam int unsigned Ticks = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       enable;
  logic [9:0] target;
  logic [9:0] actual;
  logic [9:0] duty  [5];
  logic       valid [5];

  int   n_checks = 0;
  int   n_errors = 0;
  int   mcnt = 0;
  logic en_ph = 1'b0;

  always #5 clk = ~clk;

  // 0: P-only, 1: saturating P, 2: integral ramp, 3: anti-windup, 4: derivative
  motor_speed_pid #(.UPDATE_TICKS(Ticks), .KP(256), .KI(0), .KD(0)) u_p (
    .clk_in(clk), .reset_in(rst), .clk_en(clk_en), .enable_in(enable),
    .target_rpm_in(target), .actual_rpm_in(actual),
    .duty_out(duty[0]), .duty_valid_out(valid[0]));
  motor_speed_pid #(.UPDATE_TICKS(Ticks), .KP(512), .KI(0), .KD(0)) u_sat (
    .clk_in(clk), .reset_in(rst), .clk_en(clk_en), .enable_in(enable),
    .target_rpm_in(target), .actual_rpm_in(actual),
    .duty_out(duty[1]), .duty_valid_out(valid[1]));
  motor_speed_pid #(.UPDATE_TICKS(Ticks), .KP(0), .KI(64), .KD(0)) u_int (
    .clk_in(clk), .reset_in(rst), .clk_en(clk_en), .enable_in(enable),
    .target_rpm_in(target), .actual_rpm_in(actual),
    .duty_out(duty[2]), .duty_valid_out(valid[2]));
  motor_speed_pid #(.UPDATE_TICKS(Ticks), .KP(0), .KI(256), .KD(0)) u_aw (
    .clk_in(clk), .reset_in(rst), .clk_en(clk_en), .enable_in(enable),
    .target_rpm_in(target), .actual_rpm_in(actual),
    .duty_out(duty[3]), .duty_valid_out(valid[3]));
  motor_speed_pid #(.UPDATE_TICKS(Ticks), .KP(0), .KI(0), .KD(256)) u_der (
    .clk_in(clk), .reset_in(rst), .clk_en(clk_en), .enable_in(enable),
    .target_rpm_in(target), .actual_rpm_in(actual),
    .duty_out(duty[4]), .duty_valid_out(valid[4]));

  // clk_en high on every other cycle, changed away from the active edge.
  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      en_ph  = ~en_ph;
      clk_en = en_ph;
    end
  end

  // Reference model of the tick counter.
  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else if (clk_en) mcnt <= (mcnt == Ticks - 1) ? 0 : mcnt + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Returns in the active region of the update-tick edge (before state updates).
  task automatic wait_update(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (clk_en && (mcnt == Ticks - 1) && !rst && enable) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_update(input string tag, input int idx, input int exp);
    bit ok;
    bit early;
    early = 1'b0;
    wait_update(ok);
    check_eq({tag, "_tick"}, int'(ok), 1);
    if (ok) begin
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk);
        #1;
        if (k < 6 && valid[idx]) early = 1'b1;
      end
      check_eq({tag, "_early"}, int'(early), 0);
      check_eq({tag, "_valid"}, int'(valid[idx]), 1);
      check_eq({tag, "_duty"}, int'(duty[idx]), exp);
      @(posedge clk);
      #1;
      check_eq({tag, "_pulse"}, int'(valid[idx]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    bit ok;
    rst    = 1'b1;
    enable = 1'b1;
    target = '0;
    actual = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rst_duty%0d", i), int'(duty[i]), 0);
      check_eq($sformatf("rst_valid%0d", i), int'(valid[i]), 0);
    end

    // P-only
    target = 10'd500; actual = 10'd300;
    run_update("p1", 0, 200);
    actual = 10'd600;
    run_update("p2", 0, 0);
    check_eq("p2_satlo", int'(u_p.sat_lo_q), 1);

    // Saturation without wrap
    do_reset();
    target = 10'd1023; actual = 10'd0;
    run_update("sat", 1, 1023);

    // Integral ramp
    do_reset();
    target = 10'd400; actual = 10'd300;
    run_update("int1", 2, 25);
    run_update("int2", 2, 50);
    run_update("int3", 2, 75);

    // Anti-windup
    do_reset();
    target = 10'd1023; actual = 10'd0;
    run_update("aw1", 3, 1023);
    check_eq("aw1_integ", int'(u_aw.integ_q), 1023);
    run_update("aw2", 3, 1023);
    check_eq("aw2_integ", int'(u_aw.integ_q), 1023);
    target = 10'd0; actual = 10'd1023;
    run_update("aw3", 3, 0);
    check_eq("aw3_integ", int'(u_aw.integ_q), 0);

    // Derivative
    do_reset();
    target = 10'd100; actual = 10'd0;
    run_update("d1", 4, 100);
    target = 10'd300;
    run_update("d2", 4, 200);
    run_update("d3", 4, 0);

    // Reset mid-computation (u_p holds 300, u_int integ is non-zero here)
    target = 10'd500; actual = 10'd300;
    wait_update(ok);
    check_eq("rmid_tick", int'(ok), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (valid[0]) pulses++;
    end
    check_eq("rmid_pulses", pulses, 0);
    check_eq("rmid_duty", int'(duty[0]), 0);
    check_eq("rmid_integ", int'(u_int.integ_q), 0);

    // Enable low for a full window
    run_update("en0", 0, 200);
    #1 enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("enl_duty", int'(duty[0]), 0);
    check_eq("enl_integ", int'(u_int.integ_q), 0);
    check_eq("enl_prev", int'(u_der.prev_err_q), 0);
    pulses = 0;
    for (int k = 0; k < 2 * Ticks + 4; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) if (valid[i]) pulses++;
    end
    check_eq("enl_pulses", pulses, 0);
    #1 enable = 1'b1;
    run_update("en1", 2, 50);
    check_eq("en1_dder", int'(duty[4]), 200);
    check_eq("en1_dp", int'(duty[0]), 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
